// File: rtl/rob_commit_pkg.sv
// Shared types and constants for the reorder buffer: tag, word and register
// index widths, plus the reserved zero tag.
package rob_commit_pkg;

   localparam int ROB_IDX_LN = 3;
   localparam int WORD_W     = 32;
   localparam int REG_IDX_W  = 5;

   typedef logic [ROB_IDX_LN-1:0] rob_idx_t;
   typedef logic [WORD_W-1:0]     word_t;
   typedef logic [REG_IDX_W-1:0]  reg_idx_t;

   localparam rob_idx_t ZERO_ROB_IDX  = '0;
   localparam rob_idx_t FIRST_ROB_IDX = rob_idx_t'(1);
   localparam word_t    ZERO_WORD     = '0;

endpackage

// File: rtl/rob_commit_ptr_inc.sv
// Tag pointer increment with wrap: ROB_SIZE-1 goes back to 1, skipping the
// reserved tag 0.
module rob_ptr_inc
   import rob_commit_pkg::*;
#(
   parameter int ROB_SIZE = (1 << ROB_IDX_LN)
) (
   input  logic [ROB_IDX_LN-1:0] ptr_i,
   output logic [ROB_IDX_LN-1:0] ptr_nxt_o
);

   assign ptr_nxt_o = (ptr_i == ROB_IDX_LN'(ROB_SIZE - 1)) ? FIRST_ROB_IDX : ptr_i + 1'b1;

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: allocates tags, collects CDB results, commits in order and
// raises rollback on a mispredicted branch. Optional macro ROB_WB_BYPASS_EN
// forwards the same-cycle CDB result onto the query ports.
module rob_commit
   import rob_commit_pkg::*;
#(
   parameter int ROB_SIZE = (1 << ROB_IDX_LN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  is_ena,
   input  logic [REG_IDX_W-1:0]  is_rd,
   input  logic                  is_br,
   input  logic                  is_pred,
   output logic [ROB_IDX_LN-1:0] is_idx,
   output logic                  full,
   input  logic                  wb_ena,
   input  logic [ROB_IDX_LN-1:0] wb_idx,
   input  logic [WORD_W-1:0]     wb_val,
   input  logic                  wb_taken,
   input  logic [WORD_W-1:0]     wb_tgt,
   input  logic [ROB_IDX_LN-1:0] q_idx1,
   input  logic [ROB_IDX_LN-1:0] q_idx2,
   output logic                  q_rdy1,
   output logic                  q_rdy2,
   output logic [WORD_W-1:0]     q_val1,
   output logic [WORD_W-1:0]     q_val2,
   output logic                  rob_wr_ena,
   output logic [REG_IDX_W-1:0]  rob_wr_rd,
   output logic [WORD_W-1:0]     rob_wr_val,
   output logic [ROB_IDX_LN-1:0] rob_wr_idx,
   output logic                  rb_ena,
   output logic [WORD_W-1:0]     rb_pc
);

   logic [ROB_IDX_LN-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic [ROB_IDX_LN-1:0] head_nxt, tail_nxt;
   logic [ROB_SIZE-1:0]   busy_q, ready_q, br_q, pred_q, taken_q;
   logic [REG_IDX_W-1:0]  rd_q  [ROB_SIZE];
   logic [WORD_W-1:0]     val_q [ROB_SIZE];
   logic [WORD_W-1:0]     tgt_q [ROB_SIZE];
   logic                  head_ok, do_commit, do_rb, do_alloc, do_wb;

   rob_ptr_inc #(.ROB_SIZE(ROB_SIZE)) u_head_inc (.ptr_i(head_q), .ptr_nxt_o(head_nxt));
   rob_ptr_inc #(.ROB_SIZE(ROB_SIZE)) u_tail_inc (.ptr_i(tail_q), .ptr_nxt_o(tail_nxt));

   assign full      = (count_q == ROB_IDX_LN'(ROB_SIZE - 1));
   assign is_idx    = tail_q;
   assign head_ok   = busy_q[head_q] & ready_q[head_q];
   assign do_commit = head_ok & rdy;
   assign do_rb     = do_commit & br_q[head_q] & (taken_q[head_q] ^ pred_q[head_q]);
   // A rollback flushes everything, so same-cycle allocation and writeback are dropped.
   assign do_alloc  = is_ena & ~full & rdy & ~do_rb;
   assign do_wb     = wb_ena & rdy & ~do_rb & (wb_idx != ZERO_ROB_IDX) & busy_q[wb_idx];

   assign rob_wr_ena = do_commit;
   assign rob_wr_rd  = do_commit ? rd_q[head_q]  : '0;
   assign rob_wr_val = do_commit ? val_q[head_q] : ZERO_WORD;
   assign rob_wr_idx = do_commit ? head_q        : ZERO_ROB_IDX;
   assign rb_ena     = do_rb;
   assign rb_pc      = do_rb ? tgt_q[head_q] : ZERO_WORD;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (do_rb) begin
         head_d  = FIRST_ROB_IDX;
         tail_d  = FIRST_ROB_IDX;
         count_d = '0;
      end else begin
         if (do_commit) head_d = head_nxt;
         if (do_alloc)  tail_d = tail_nxt;
         case ({do_alloc, do_commit})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= FIRST_ROB_IDX;
         tail_q  <= FIRST_ROB_IDX;
         count_q <= '0;
         busy_q  <= '0;
         ready_q <= '0;
         br_q    <= '0;
         pred_q  <= '0;
         taken_q <= '0;
         for (int i = 0; i < ROB_SIZE; i++) begin
            rd_q[i]  <= '0;
            val_q[i] <= ZERO_WORD;
            tgt_q[i] <= ZERO_WORD;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (do_rb) begin
            busy_q  <= '0;
            ready_q <= '0;
         end else begin
            if (do_wb) begin
               ready_q[wb_idx] <= 1'b1;
               val_q[wb_idx]   <= wb_val;
               taken_q[wb_idx] <= wb_taken;
               tgt_q[wb_idx]   <= wb_tgt;
            end
            // Freeing the head comes after the writeback so a stray late result cannot revive it.
            if (do_commit) begin
               busy_q[head_q]  <= 1'b0;
               ready_q[head_q] <= 1'b0;
            end
            if (do_alloc) begin
               busy_q[tail_q]  <= 1'b1;
               ready_q[tail_q] <= 1'b0;
               rd_q[tail_q]    <= is_rd;
               br_q[tail_q]    <= is_br;
               pred_q[tail_q]  <= is_pred;
            end
         end
      end
   end

   always_comb begin
      q_rdy1 = busy_q[q_idx1] & ready_q[q_idx1];
      q_val1 = val_q[q_idx1];
      q_rdy2 = busy_q[q_idx2] & ready_q[q_idx2];
      q_val2 = val_q[q_idx2];
`ifdef ROB_WB_BYPASS_EN
      if (wb_ena && (wb_idx == q_idx1) && (q_idx1 != ZERO_ROB_IDX) && busy_q[q_idx1]) begin
         q_rdy1 = 1'b1;
         q_val1 = wb_val;
      end
      if (wb_ena && (wb_idx == q_idx2) && (q_idx2 != ZERO_ROB_IDX) && busy_q[q_idx2]) begin
         q_rdy2 = 1'b1;
         q_val2 = wb_val;
      end
`endif
   end

endmodule
